bls_operand_server: RTL
=======================

// Module: bls_operand_server
// PURPOSE
//  Upstream data stage for the Black-Scholes controller. Serves SERVE_REG requests by reading
//  one option record (NFIELDS words) from a 1-cycle-latency BRAM into that module's operand
//  slot. Reports per-slot hasUnusedData/REG_READY and global OutOfData back to the controller.
//  Slot contents feed the BS pricing modules directly.
// PARAMETERS
//  BSMODS   1   number of BS modules / operand slots
//  NFIELDS  5   words per record (spot, strike, rate, vol, time)
//  WORD_W   32  operand word width
//  ADDR_W   12  BRAM word-address width
//  REC_W    8   record index / tag width
// PORTS
//  clock          in   1                   clock
//  reset          in   1                   asynchronous, active-high
//  start          in   1                   begin serving (same pulse as controller startSystem)
//  num_records    in   REC_W               records in BRAM; sampled on start
//  SERVE_REG      in   BSMODS              per-slot refill request from controller
//  BS_START       in   BSMODS              per-slot consume strobe (BS module latches operands)
//  mem_en         out  1                   BRAM read enable
//  mem_addr       out  ADDR_W              BRAM word address
//  mem_rdata      in   WORD_W              BRAM data, valid 1 cycle after mem_en
//  op_data        out  BSMODS*NFIELDS*WORD_W  slot i field f at [(i*NFIELDS+f)*WORD_W +: WORD_W]
//  op_tag         out  BSMODS*REC_W        record index held in each slot
//  hasUnusedData  out  BSMODS              slot claimed by a record not yet started
//  REG_READY      out  BSMODS              slot fully loaded
//  OutOfData      out  1                   every record has been granted
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rec_cnt 0; rr pointer 0; op_data/op_tag 0.
//  FSM: IDLE -start-> ARB. If num_records==0: -> DONE instead.
//   ARB: if any SERVE_REG[i] && !hasUnusedData[i], round-robin grant (pointer = grantee+1 mod BSMODS).
//    Set hasUnusedData[i] and op_tag[i]=rec_cnt; clear REG_READY[i]; rec_cnt++ -> FETCH.
//    No valid request: stay ARB.
//   FETCH: NFIELDS cycles; mem_en=1, mem_addr=rec*NFIELDS+f for f=0..NFIELDS-1.
//    Capture mem_rdata into field f one cycle later (delayed field index). After the last address -> DRAIN.
//   DRAIN: capture the last field; set REG_READY[i].
//    Then ARB if rec_cnt<num_records, else DONE.
//   DONE: terminal until reset; slots keep serving BS_START clears.
//  Latency: request seen in ARB at cycle 0 -> REG_READY[i] high at cycle NFIELDS+2 (7 for default).
//  OutOfData: registered; goes high the cycle after the grant of the final record.
//   The final slot's hasUnusedData is already high then, so the controller cannot finish early.
//  BS_START[i] with REG_READY[i]: clear hasUnusedData[i] and REG_READY[i] next edge.
//   op_data/op_tag hold their values.
//  BS_START[i] without REG_READY[i] (mid-fill): ignored.
//  SERVE_REG[i] with hasUnusedData[i] set: ignored. SERVE_REG after OutOfData: ignored.
//  start outside IDLE: ignored. mem_en is 0 outside FETCH.
//  Multiple simultaneous requests: one grant per ARB visit; others wait, no request lost.
//  Address arithmetic at ADDR_W, unsigned. num_records*NFIELDS must fit ADDR_W; larger values are illegal.
//  Reset mid-FETCH: immediate return to reset state; partial slot discarded.
// STRUCTURE
//  bls_pkg: NFIELDS, field index enum (FLD_SPOT..FLD_TIME), server state typedef
//   {IDLE,ARB,FETCH,DRAIN,DONE}. BSMODS moves here from its current global parameter.
//  Sub-module: bls_rr_arbiter (BSMODS req -> one-hot grant + valid, pointer update on grant).
//  Slot register file and capture pipeline stay in this module.
// TESTING
//  1 BSMODS=1, num_records=3, SERVE_REG held while !hasUnusedData, BS_START 2 cyc after REG_READY
//    -> addresses 0..14 in order; op_tag 0,1,2; REG_READY 7 cyc after each grant;
//    OutOfData high after 3rd grant.
//  2 BSMODS=4, all SERVE_REG high at once -> grants slots 0,1,2,3 in order;
//    each slot's fields equal BRAM words of record 0..3.
//  3 num_records=0, start -> OutOfData=1 next cycle; mem_en never asserted; state DONE.
//  4 BS_START[0] pulsed during FETCH of slot 0 -> ignored; REG_READY[0] still rises;
//    hasUnusedData[0] stays 1.
//  5 Assert reset during the 3rd FETCH cycle -> all outputs 0 the same cycle;
//    restart with start re-reads record 0.
//  6 Slot 1 requests continuously, slot 0 requests once, BSMODS=2 -> slot 0 granted
//    within one fill of its request (no starvation).

Source files
------------

// File: rtl/bls_pkg.sv
// Shared types and constants for the Black-Scholes operand server: record layout,
// field indices and the server FSM state encoding.
package bls_pkg;

  localparam int BSMODS  = 1;
  localparam int NFIELDS = 5;

  typedef enum logic [2:0] {
    FLD_SPOT,
    FLD_STRIKE,
    FLD_RATE,
    FLD_VOL,
    FLD_TIME
  } field_t;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    FETCH,
    DRAIN,
    DONE
  } srv_state_t;

endpackage

// File: rtl/bls_rr_arbiter.sv
// Round-robin arbiter: one-hot grant for the first requester at or after the pointer;
// the pointer moves past the grantee whenever a grant is issued.
module bls_rr_arbiter #(
  parameter int N     = 1,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] ptr;

  always_comb begin
    int c;
    // NOTE: every output gets a default before the search so no path can infer a latch.
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!valid && req[c]) begin
        valid    = 1'b1;
        grant[c] = 1'b1;
        idx      = IDX_W'(c);
      end
    end
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (valid) begin
      ptr <= (int'(idx) == N - 1) ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/bls_operand_server.sv
// Operand server: grants BRAM option records to BS module slots round-robin, streams the
// record's fields through a one-cycle-latency read into the slot, and tracks slot status.
module bls_operand_server
  import bls_pkg::*;
#(
  parameter int BSMODS = bls_pkg::BSMODS,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 12,
  parameter int REC_W  = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [REC_W-1:0]                 num_records,
  input  logic [BSMODS-1:0]                SERVE_REG,
  input  logic [BSMODS-1:0]                BS_START,
  output logic                             mem_en,
  output logic [ADDR_W-1:0]                mem_addr,
  input  logic [WORD_W-1:0]                mem_rdata,
  output logic [BSMODS*NFIELDS*WORD_W-1:0] op_data,
  output logic [BSMODS*REC_W-1:0]          op_tag,
  output logic [BSMODS-1:0]                hasUnusedData,
  output logic [BSMODS-1:0]                REG_READY,
  output logic                             OutOfData
);

  localparam int SLOT_W = (BSMODS > 1) ? $clog2(BSMODS) : 1;

  srv_state_t         state;
  logic [REC_W-1:0]   rec_cnt;
  logic [REC_W-1:0]   rec_total;
  logic [SLOT_W-1:0]  cur_slot;
  field_t             fld;
  field_t             cap_fld;
  logic               cap_en;
  logic [WORD_W-1:0]  slot_data [BSMODS][NFIELDS];
  logic [REC_W-1:0]   slot_tag  [BSMODS];

  logic [BSMODS-1:0]  arb_req;
  logic [BSMODS-1:0]  grant;
  logic               grant_valid;
  logic [SLOT_W-1:0]  grant_idx;

  // A slot already holding an unstarted record cannot be refilled.
  assign arb_req = (state == ARB && !OutOfData) ? (SERVE_REG & ~hasUnusedData) : '0;

  bls_rr_arbiter #(
    .N     (BSMODS),
    .IDX_W (SLOT_W)
  ) u_arb (
    .clock (clock),
    .reset (reset),
    .req   (arb_req),
    .grant (grant),
    .valid (grant_valid),
    .idx   (grant_idx)
  );

  for (genvar i = 0; i < BSMODS; i++) begin : g_slot
    assign op_tag[i*REC_W +: REC_W] = slot_tag[i];
    for (genvar f = 0; f < NFIELDS; f++) begin : g_fld
      assign op_data[(i*NFIELDS+f)*WORD_W +: WORD_W] = slot_data[i][f];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rec_cnt       <= '0;
      rec_total     <= '0;
      cur_slot      <= '0;
      fld           <= FLD_SPOT;
      cap_fld       <= FLD_SPOT;
      cap_en        <= 1'b0;
      mem_en        <= 1'b0;
      mem_addr      <= '0;
      hasUnusedData <= '0;
      REG_READY     <= '0;
      OutOfData     <= 1'b0;
      // NOTE: the slot array is a bank of flops driving the pricers, not a RAM, so it is
      // reset like any other register and reads as zero out of reset.
      for (int i = 0; i < BSMODS; i++) begin
        slot_tag[i] <= '0;
        for (int f = 0; f < NFIELDS; f++) slot_data[i][f] <= '0;
      end
    end else begin
      // Read data lags the address by one cycle, so capture uses the previous field index.
      cap_en  <= (state == FETCH);
      cap_fld <= fld;
      if (cap_en) slot_data[cur_slot][cap_fld] <= mem_rdata;

      for (int i = 0; i < BSMODS; i++) begin
        if (BS_START[i] && REG_READY[i]) begin
          hasUnusedData[i] <= 1'b0;
          REG_READY[i]     <= 1'b0;
        end
        if (grant[i]) begin
          hasUnusedData[i] <= 1'b1;
          REG_READY[i]     <= 1'b0;
          slot_tag[i]      <= rec_cnt;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            rec_total <= num_records;
            rec_cnt   <= '0;
            if (num_records == '0) begin
              OutOfData <= 1'b1;
              state     <= DONE;
            end else begin
              state <= ARB;
            end
          end
        end
        ARB: begin
          if (grant_valid) begin
            cur_slot  <= grant_idx;
            rec_cnt   <= rec_cnt + REC_W'(1);
            OutOfData <= (rec_cnt + REC_W'(1) == rec_total);
            fld       <= FLD_SPOT;
            mem_en    <= 1'b1;
            mem_addr  <= ADDR_W'(rec_cnt) * ADDR_W'(NFIELDS);
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (fld == FLD_TIME) begin
            mem_en <= 1'b0;
            state  <= DRAIN;
          end else begin
            fld      <= fld.next();
            mem_addr <= mem_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          REG_READY[cur_slot] <= 1'b1;
          state <= (rec_cnt < rec_total) ? ARB : DONE;
        end
        DONE: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
